integral_image_writer: RTL and testbench
========================================

// Module: integral_image_writer
//
// PURPOSE
//   Builds the integral image of a raster pixel stream and writes it into the
//   integral-image cache via the cache write port (waddrY/waddrX/wdata/we).
//   Per pixel: reads I(x,y-1) back through the write port's read data (q),
//   adds the running row sum, then writes I(x,y).
//   Sits between the frame source and the cache; the window reader consumes
//   the cache on its read port.
//
// PARAMETERS
//   IMG_W      320  pixels per row
//   IMG_H      240  rows per frame
//   PIX_W      8    pixel width
//   WORD_SIZE  32   integral word width; equals cache WORD_SIZE
//   X_W        9    column address width, >= clog2(IMG_W)
//   Y_W        8    row address width, >= clog2(IMG_H)
//   RD_LAT     2    cycles from a we=0 address issue to valid q_in (cache input reg + RAM reg)
//
// PORTS
//   clk        in   1          clock
//   rst_n      in   1          asynchronous, active-low reset
//   pix_valid  in   1          pixel offered
//   pix_ready  out  1          pixel accepted when pix_valid & pix_ready
//   pix_data   in   PIX_W      pixel value, unsigned
//   pix_sof    in   1          qualifies the first pixel of a frame
//   waddr_y    out  Y_W        cache row address
//   waddr_x    out  X_W        cache column address
//   wdata      out  WORD_SIZE  integral value to write
//   we         out  1          write enable; address with we=0 is a read
//   q_in       in   WORD_SIZE  cache write-port read data
//   frame_done out  1          1-cycle pulse after the last write of a frame
//   sync_err   out  1          1-cycle pulse on sof while not at (0,0)
//   busy       out  1          high from first accepted pixel to frame_done
//
// BEHAVIOUR
// Reset
//   - All outputs 0: pix_ready=0, we=0, waddr_y/x=0, wdata=0.
//   - x=y=0, row_sum=0, state IDLE.
//   - Asynchronous reset mid-frame: the next frame restarts at (0,0).
//   - Partially written cache contents are don't-care.
// FSM
//   IDLE
//     - pix_ready=1.
//     - On accept: latch pixel; row_sum_n = (x==0 ? 0 : row_sum) + pixel.
//     - y==0 -> WRITE; else -> READ.
//   READ (1 cycle)
//     - Drive waddr=(y-1,x), we=0; start wait counter at RD_LAT-1 -> WAIT.
//   WAIT
//     - Decrement the counter; at 0, capture above=q_in -> WRITE.
//   WRITE (1 cycle)
//     - Drive waddr=(y,x), we=1, wdata=row_sum_n + above (above=0 when y==0).
//     - row_sum<=row_sum_n; advance x, wrapping at IMG_W-1 to 0 with y+1.
//     - At (IMG_W-1, IMG_H-1): pulse frame_done next cycle, y=0, clear busy.
//     - -> IDLE.
// Port and handshake rules
//   - pix_ready is high only in IDLE: at most one pixel in flight.
//   - Throughput: 1 pixel per 2 cycles (row 0), 1 per RD_LAT+3 cycles (other rows).
//   - we is high only in WRITE.
//   - waddr/wdata are registered outputs, held stable outside READ/WRITE.
// Arithmetic
//   - Unsigned, modulo 2^WORD_SIZE; no saturation.
//   - row_sum is WORD_SIZE wide; pixel is zero-extended.
// Sync
//   - pix_sof accepted at (0,0): normal.
//   - pix_sof accepted elsewhere: pulse sync_err; treat the pixel as (0,0) of a new frame.
//   - No frame_done is issued for the abandoned frame.
//   - A pixel at (0,0) without sof is accepted as frame start; sof is not required.
//
// TESTING (bench uses IMG_W=4, IMG_H=3, RD_LAT=2, cache model with 2-cycle q)
//   - 12 pixels of value 1: writes I(x,y)=(x+1)(y+1); last write (3,2)=12,
//     then frame_done 1 cycle later.
//   - Pixels 0..11 raster: row-0 writes 0,1,3,6; (3,2) write = 66.
//   - pix_valid toggling randomly: identical write sequence to the previous
//     test; pix_ready never high outside IDLE; no pixel lost or duplicated.
//   - pix_sof on the 6th pixel: sync_err pulse; that pixel written at (0,0)
//     with wdata=pixel; no frame_done for the old frame.
//   - rst_n low during WAIT on row 1: we=0 immediately; next frame of all-1s
//     gives correct (x+1)(y+1).
//   - WORD_SIZE=8, all pixels 255: wdata wraps mod 256, e.g. (1,0)=254.

Source files
------------

// File: rtl/integral_image_writer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : integral_image_writer                                         |
// | Purpose  : Builds the integral image of a raster pixel stream and writes |
// |            it into the integral-image cache through its write port.      |
// |            For rows below the first, I(x,y-1) is read back through the   |
// |            same port (we=0) before I(x,y) is written.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module integral_image_writer #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int PIX_W     = 8,
  parameter int WORD_SIZE = 32,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_sof,
  output logic [Y_W-1:0]       waddr_y,
  output logic [X_W-1:0]       waddr_x,
  output logic [WORD_SIZE-1:0] wdata,
  output logic                 we,
  input  logic [WORD_SIZE-1:0] q_in,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic                 busy
);

  // The wait counter only has to hold RD_LAT-1; keep at least one bit.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [X_W-1:0]   c_X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   c_Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] c_WAIT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [WORD_SIZE-1:0] r_row_sum;
  logic [WORD_SIZE-1:0] r_row_sum_n;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_pix_ready;
  logic [Y_W-1:0]       r_waddr_y;
  logic [X_W-1:0]       r_waddr_x;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_we;
  logic                 r_frame_done;
  logic                 r_sync_err;
  logic                 r_busy;

  logic [X_W-1:0]       w_x;
  logic [Y_W-1:0]       w_y;
  logic                 w_resync;
  logic [WORD_SIZE-1:0] w_pix_ext;
  logic [WORD_SIZE-1:0] w_row_sum_n;

  // Position of the offered pixel: a start-of-frame marker forces (0,0),
  // abandoning whatever frame was in progress. The running row sum restarts
  // at the first column of every row.
  always_comb begin
    w_x         = pix_sof ? '0 : r_x;
    w_y         = pix_sof ? '0 : r_y;
    w_resync    = pix_sof && ((r_x != '0) || (r_y != '0));
    w_pix_ext   = WORD_SIZE'(pix_data);
    w_row_sum_n = ((w_x == '0) ? '0 : r_row_sum) + w_pix_ext;
  end

  // Control FSM: one pixel in flight, optional read of the row above, then write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_row_sum    <= '0;
      r_row_sum_n  <= '0;
      r_cnt        <= '0;
      r_pix_ready  <= 1'b0;
      r_waddr_y    <= '0;
      r_waddr_x    <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_pix_ready) begin
            // First cycle after reset: open the input.
            r_pix_ready <= 1'b1;
          end else if (pix_valid) begin
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_sync_err  <= w_resync;
            r_x         <= w_x;
            r_y         <= w_y;
            r_row_sum_n <= w_row_sum_n;
            if (w_y == '0) begin
              // Top row has nothing above it: write straight away.
              r_state   <= S_WRITE;
              r_waddr_y <= w_y;
              r_waddr_x <= w_x;
              r_wdata   <= w_row_sum_n;
              r_we      <= 1'b1;
            end else begin
              // Present the address of the pixel above as a read.
              r_state   <= S_READ;
              r_waddr_y <= w_y - 1'b1;
              r_waddr_x <= w_x;
            end
          end
        end

        S_READ: begin
          r_cnt   <= c_WAIT_INIT;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (r_cnt == '0) begin
            // Read data for the row above is valid this cycle.
            r_state   <= S_WRITE;
            r_waddr_y <= r_y;
            r_waddr_x <= r_x;
            r_wdata   <= r_row_sum_n + q_in;
            r_we      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_WRITE: begin
          r_we        <= 1'b0;
          r_row_sum   <= r_row_sum_n;
          r_pix_ready <= 1'b1;
          r_state     <= S_IDLE;
          if (r_x == c_X_LAST) begin
            r_x <= '0;
            if (r_y == c_Y_LAST) begin
              r_y          <= '0;
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_y <= r_y + 1'b1;
            end
          end else begin
            r_x <= r_x + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pix_ready  = r_pix_ready;
  assign waddr_y    = r_waddr_y;
  assign waddr_x    = r_waddr_x;
  assign wdata      = r_wdata;
  assign we         = r_we;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_integral_image_writer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_integral_image_writer                                      |
// | Purpose  : Directed self-checking bench for integral_image_writer on a   |
// |            4x3 image with a 2-cycle-latency cache model.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_integral_image_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int PIX_W  = 8;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int RD_LAT = 2;
  localparam int NPIX   = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;

  logic             pix_ready, we, frame_done, sync_err, busy;
  logic [Y_W-1:0]   waddr_y;
  logic [X_W-1:0]   waddr_x;
  logic [31:0]      wdata, q_in;

  logic             pix_ready_8, we_8, frame_done_8, sync_err_8, busy_8;
  logic [Y_W-1:0]   waddr_y_8;
  logic [X_W-1:0]   waddr_x_8;
  logic [7:0]       wdata_8, q_in_8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  integral_image_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .WORD_SIZE(32),
    .X_W(X_W), .Y_W(Y_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .waddr_y(waddr_y), .waddr_x(waddr_x),
    .wdata(wdata), .we(we), .q_in(q_in), .frame_done(frame_done),
    .sync_err(sync_err), .busy(busy)
  );

  integral_image_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .WORD_SIZE(8),
    .X_W(X_W), .Y_W(Y_W), .RD_LAT(RD_LAT)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_8),
    .pix_data(pix_data), .pix_sof(pix_sof), .waddr_y(waddr_y_8), .waddr_x(waddr_x_8),
    .wdata(wdata_8), .we(we_8), .q_in(q_in_8), .frame_done(frame_done_8),
    .sync_err(sync_err_8), .busy(busy_8)
  );

  // Cache models: registered address, then registered RAM output.
  logic [31:0]    mem  [IMG_H][IMG_W];
  logic [7:0]     mem8 [IMG_H][IMG_W];
  logic [Y_W-1:0] a_y, a_y8;
  logic [X_W-1:0] a_x, a_x8;

  always @(posedge clk) begin
    if (we && int'(waddr_y) < IMG_H && int'(waddr_x) < IMG_W)
      mem[int'(waddr_y)][int'(waddr_x)] <= wdata;
    a_y  <= waddr_y;
    a_x  <= waddr_x;
    q_in <= (int'(a_y) < IMG_H && int'(a_x) < IMG_W) ? mem[int'(a_y)][int'(a_x)] : 32'd0;
    if (we_8 && int'(waddr_y_8) < IMG_H && int'(waddr_x_8) < IMG_W)
      mem8[int'(waddr_y_8)][int'(waddr_x_8)] <= wdata_8;
    a_y8   <= waddr_y_8;
    a_x8   <= waddr_x_8;
    q_in_8 <= (int'(a_y8) < IMG_H && int'(a_x8) < IMG_W) ? mem8[int'(a_y8)][int'(a_x8)] : 8'd0;
  end

  // Write/pulse monitor sampled on the falling edge.
  int          cyc = 0;
  logic [63:0] wr_q[$];
  int          wr_cyc[$];
  logic [7:0]  wr8_q[$];
  int          fd_n = 0, fd_cyc = 0, se_n = 0, viol = 0;
  bit          inflight = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      if (inflight && pix_ready) viol <= viol + 1;
      if (we) begin
        wr_q.push_back({15'd0, waddr_y, waddr_x, wdata});
        wr_cyc.push_back(cyc);
        wr8_q.push_back(wdata_8);
        inflight <= 1'b0;
      end else if (pix_valid && pix_ready) begin
        inflight <= 1'b1;
      end
      if (frame_done) begin
        fd_n   <= fd_n + 1;
        fd_cyc <= cyc;
      end
      if (sync_err) se_n <= se_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int y, input int x, input logic [31:0] d);
    return {15'd0, Y_W'(y), X_W'(x), d};
  endfunction

  function automatic logic [31:0] integ(input int p[NPIX], input int x, input int y);
    logic [31:0] s = 32'd0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s = s + 32'(p[j*IMG_W + i]);
    return s;
  endfunction

  task automatic send(input int p, input bit sof, input bit rnd);
    int guard = 0;
    do begin
      @(negedge clk);
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = PIX_W'(p);
      pix_sof   = sof;
      guard++;
    end while (!(pix_valid && pix_ready) && guard < 200);
    if (guard >= 200) check("ready_timeout", {63'd0, pix_ready}, 64'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int p[NPIX], input bit rnd);
    for (int i = 0; i < NPIX; i++) send(p[i], (i == 0), rnd);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input int p[NPIX]);
    check({tag, "_count"}, 64'(wr_q.size() - base), 64'(NPIX));
    for (int i = 0; i < NPIX && base + i < wr_q.size(); i++)
      check(tag, wr_q[base + i], pk(i / IMG_W, i % IMG_W, integ(p, i % IMG_W, i / IMG_W)));
  endtask

  int p_ones[NPIX], p_ramp[NPIX], p_sync[NPIX], p_max[NPIX];
  int base, fd0, se0;

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      p_ones[i] = 1;
      p_ramp[i] = i;
      p_sync[i] = (i == 0) ? 7 : 1;
      p_max[i]  = 255;
    end
    rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", {63'd0, pix_ready}, 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_addr", {47'd0, waddr_y, waddr_x}, 64'd0);
    check("rst_wdata", {32'd0, wdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // All ones: I(x,y) = (x+1)(y+1)
    base = wr_q.size(); fd0 = fd_n; se0 = se_n;
    send(1, 1'b1, 1'b0);
    check("busy_set", {63'd0, busy}, 64'd1);
    for (int i = 1; i < NPIX; i++) send(1, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check_frame("ones", base, p_ones);
    if (wr_q.size() >= base + NPIX) begin
      check("ones_last", wr_q[base + NPIX - 1], pk(2, 3, 32'd12));
      check("fd_delay", 64'(fd_cyc - wr_cyc[base + NPIX - 1]), 64'd1);
    end
    check("ones_fd", 64'(fd_n - fd0), 64'd1);
    check("ones_no_serr", 64'(se_n - se0), 64'd0);
    check("busy_clr", {63'd0, busy}, 64'd0);

    // Ramp 0..11, no sof at all: frame starts at (0,0) anyway
    base = wr_q.size();
    for (int i = 0; i < NPIX; i++) send(p_ramp[i], 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check_frame("ramp", base, p_ramp);
    if (wr_q.size() >= base + NPIX) begin
      check("ramp_r0_0", wr_q[base + 0], pk(0, 0, 32'd0));
      check("ramp_r0_1", wr_q[base + 1], pk(0, 1, 32'd1));
      check("ramp_r0_2", wr_q[base + 2], pk(0, 2, 32'd3));
      check("ramp_r0_3", wr_q[base + 3], pk(0, 3, 32'd6));
      check("ramp_last", wr_q[base + NPIX - 1], pk(2, 3, 32'd66));
      check("rate_row0", 64'(wr_cyc[base + 1] - wr_cyc[base]), 64'd2);
      check("rate_row1", 64'(wr_cyc[base + 5] - wr_cyc[base + 4]), 64'(RD_LAT + 3));
    end

    // Ramp again with random valid gaps
    base = wr_q.size(); fd0 = fd_n;
    send_frame(p_ramp, 1'b1);
    check_frame("rnd", base, p_ramp);
    check("rnd_fd", 64'(fd_n - fd0), 64'd1);
    check("ready_in_flight", 64'(viol), 64'd0);

    // sof on the 6th pixel restarts the frame
    base = wr_q.size(); fd0 = fd_n; se0 = se_n;
    for (int i = 0; i < 5; i++) send(10 + i, (i == 0), 1'b0);
    for (int i = 0; i < NPIX; i++) send(p_sync[i], (i == 0), 1'b0);
    repeat (8) @(negedge clk);
    check("sync_serr", 64'(se_n - se0), 64'd1);
    check("sync_fd", 64'(fd_n - fd0), 64'd1);
    if (wr_q.size() >= base + 5) begin
      check("sync_old_10", wr_q[base + 4], pk(1, 0, 32'd24));
      check("sync_old_30", wr_q[base + 3], pk(0, 3, 32'd46));
    end
    if (wr_q.size() >= base + 6) check("sync_restart", wr_q[base + 5], pk(0, 0, 32'd7));
    check_frame("sync", base + 5, p_sync);

    // Asynchronous reset while waiting on the row-1 read
    base = wr_q.size();
    for (int i = 0; i < 5; i++) send(1, (i == 0), 1'b0);
    @(posedge clk);
    #1;
    check("busy_pre_rst", {63'd0, busy}, 64'd1);
    check("wdata_pre_rst", {32'd0, wdata}, 64'd4);
    rst_n = 1'b0;
    #1;
    check("arst_we", {63'd0, we}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_wdata", {32'd0, wdata}, 64'd0);
    check("arst_ready", {63'd0, pix_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("arst_writes", 64'(wr_q.size() - base), 64'd4);
    base = wr_q.size();
    send_frame(p_ones, 1'b0);
    check_frame("post_rst", base, p_ones);

    // All 255: the 8-bit instance wraps mod 256, the 32-bit one does not
    base = wr_q.size();
    send_frame(p_max, 1'b0);
    check_frame("max32", base, p_max);
    if (wr8_q.size() >= base + NPIX) begin
      check("wrap_10", {56'd0, wr8_q[base + 1]}, 64'd254);
      for (int i = 0; i < NPIX; i++)
        check("wrap8", {56'd0, wr8_q[base + i]},
              {56'd0, integ(p_max, i % IMG_W, i / IMG_W) & 32'hFF});
      check("max32_last", wr_q[base + NPIX - 1], pk(2, 3, 32'd3060));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
